floppy_sd_arbiter: RTL and testbench
====================================

# floppy_sd_arbiter

Shares one SD block-device port between the two Disk II drive track buffers (drive 1 and drive 2 `floppy_track` instances). Each sector request is granted whole, in round-robin order. The grantee's LBA and direction are forwarded upstream, and the ack and buffer strobes are steered back to it alone. The block sits between the per-drive track buffers and the single SD channel of the host I/O core.

## Interface
Parameters: none. The block serves exactly two clients, 0 and 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high. It is one clock; reset is synchronous and active-high.
- `sd_lba` out 32: LBA of the granted request, registered.
- `sd_rd` out 1: upstream read request, registered.
- `sd_wr` out 1: upstream write request, registered.
- `sd_ack` in 1: upstream transfer acknowledge; high for the whole sector.
- `sd_buff_addr` in 9: upstream buffer byte address; broadcast to both clients.
- `sd_buff_dout` in 8: upstream read data; broadcast to both clients.
- `sd_buff_din` out 8: write data, combinationally muxed from the granted client.
- `sd_buff_wr` in 1: upstream buffer write strobe.
- `d0_lba`, `d1_lba` in 32: client LBA.
- `d0_rd`, `d1_rd` in 1: client read request (level, held until its ack).
- `d0_wr`, `d1_wr` in 1: client write request (level, held until its ack).
- `d0_ack`, `d1_ack` out 1: steered `sd_ack`.
- `d0_buff_din`, `d1_buff_din` in 8: client write data.
- `d0_buff_wr`, `d1_buff_wr` out 1: steered `sd_buff_wr`.
- `owner` out 1: index of the current or last grantee.
- `busy` out 1: high in any state other than IDLE.

## Operation
States:
- IDLE: accepts new requests.
- XFER: an upstream request is in flight.
- RELEASE: one-cycle arbitration gap.

Request and grant:
- Client n is requesting when `dn_rd | dn_wr`.
- If both clients request, the grant goes to the client that is not `last`.
- If only one client requests, it is granted regardless of `last`.
- On grant in IDLE:
  - latch `grant` and set `last <= grant`;
  - latch `sd_lba <= dn_lba`;
  - latch the direction; `dn_wr` wins if both `dn_rd` and `dn_wr` are high;
  - assert `sd_wr` or `sd_rd`;
  - clear `orphan`;
  - go to XFER.

XFER:
- `sd_rd` and `sd_wr` clear on the first edge that samples `sd_ack` high.
- If the grantee drops both its rd and wr while `sd_ack` is still low, set `orphan`:
  - upstream `sd_rd`/`sd_wr` clear at once;
  - the state remains XFER, because the host may already have latched the request.
- Falling edge of `sd_ack` (registered `old_ack` = 1, `sd_ack` = 0) moves to RELEASE.
- While `orphan` is set and `sd_ack` has not yet risen, a new grantee request does not clear `orphan`.

RELEASE:
- Lasts one cycle, then goes to IDLE.
- The gap lets a client that re-requests on its ack fall compete fairly with the other client.

Steering (combinational):
- `dn_ack = sd_ack & (state==XFER) & (grant==n) & ~orphan`.
- `dn_buff_wr = sd_buff_wr & dn_ack`.
- `sd_buff_din = grant ? d1_buff_din : d0_buff_din`.
- The non-granted client's ack and buff_wr are 0 at all times.

Reset:
- Any state goes to IDLE.
- `sd_rd = sd_wr = 0`, `sd_lba = 0`, `grant = owner = 0`.
- `last = 1`, so client 0 is served first.
- `orphan = 0`, `old_ack = 0`.
- If reset hits mid-transfer, upstream requests drop and the acks are masked on the next cycle. A late `sd_ack` then arriving in IDLE is ignored.

Simultaneous events:
- A request that appears in the same cycle as reset is ignored.
- A `sd_ack` fall and a new request in the same cycle: the new request is honoured only after RELEASE.

## Timing
- Grant latency: a request sampled at edge k in IDLE drives `sd_rd`/`sd_wr`/`sd_lba` valid after edge k.
- Request drop: `sd_rd`/`sd_wr` fall after the first edge that samples `sd_ack` = 1.
- Back-to-back spacing: `sd_ack` sampled low at edge k (fall) gives RELEASE after k, IDLE after k+1, next issue at edge k+2 at the earliest.
- The data path adds zero latency: buffer strobes, address and data pass through in the same cycle.
- Outputs after reset: all 0.

## Test plan
- **Single read.** d0_rd=1, d0_lba=13 →
  - `sd_rd` is high 1 cycle later with `sd_lba`=13;
  - d0_ack mirrors `sd_ack`, d0_buff_wr mirrors `sd_buff_wr`;
  - d1_ack stays 0;
  - `busy` falls 2 cycles after the ack fall.
- **Contention.** d0_rd and d1_rd are high together and each re-requests on its ack fall →
  - the grant order is 0,1,0,1 across 4 sectors;
  - `sd_lba` alternates d0_lba/d1_lba;
  - each issue lands at the ack-fall edge +2.
- **Write direction.** d1_wr=1 and d1_rd=1, d1_buff_din=0xA5, d0_buff_din=0x3C →
  - `sd_wr`=1 and `sd_rd`=0;
  - `sd_buff_din`=0xA5 during the transfer.
- **Orphan.** d0_rd rises, then drops before `sd_ack` →
  - `sd_rd` clears next cycle;
  - the later 4-cycle `sd_ack` pulse gives d0_ack=0 and d0_buff_wr=0;
  - IDLE is reached after the pulse, and a pending d1 request is then granted.
- **Reset mid-transfer.** Reset is asserted while `sd_ack`=1 →
  - `sd_rd`/`sd_wr`, d0_ack and d1_ack are 0 from the next cycle;
  - `busy`=0;
  - the first request after reset with both clients requesting is granted to client 0.

Source files
------------

// File: rtl/floppy_sd_arbiter_if.sv
// rtl/floppy_sd_arbiter_if.sv - shared SD port plus the two floppy track-buffer clients
interface floppy_sd_arbiter_if;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic [7:0]  sd_buff_din;
   logic        sd_buff_wr;

   logic [31:0] d0_lba;
   logic [31:0] d1_lba;
   logic        d0_rd;
   logic        d1_rd;
   logic        d0_wr;
   logic        d1_wr;
   logic        d0_ack;
   logic        d1_ack;
   logic [7:0]  d0_buff_din;
   logic [7:0]  d1_buff_din;
   logic        d0_buff_wr;
   logic        d1_buff_wr;

   logic        owner;
   logic        busy;

   // Address and read data are broadcast straight through the interface, so the
   // arbiter side never touches them.
   modport master (
      output sd_lba, sd_rd, sd_wr, sd_buff_din,
      output d0_ack, d1_ack, d0_buff_wr, d1_buff_wr, owner, busy,
      input  sd_ack, sd_buff_wr,
      input  d0_lba, d1_lba, d0_rd, d1_rd, d0_wr, d1_wr, d0_buff_din, d1_buff_din
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_buff_din,
      input  d0_ack, d1_ack, d0_buff_wr, d1_buff_wr, owner, busy,
      output sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout,
      output d0_lba, d1_lba, d0_rd, d1_rd, d0_wr, d1_wr, d0_buff_din, d1_buff_din
   );
endinterface

// File: rtl/floppy_sd_arbiter.sv
// rtl/floppy_sd_arbiter.sv - round-robin sector arbiter sharing one SD port between two drives
module floppy_sd_arbiter (
   input  logic                clk,
   input  logic                reset,
   floppy_sd_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      XFER    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic        orphan_q, orphan_d;
   logic        old_ack_q, old_ack_d;
   logic        sd_rd_q, sd_rd_d;
   logic        sd_wr_q, sd_wr_d;
   logic [31:0] sd_lba_q, sd_lba_d;

   logic        req0, req1, any_req;
   logic        pick, pick_wr, grantee_req, ack_fall, in_xfer;
   logic [31:0] pick_lba;

   assign req0        = bus.d0_rd | bus.d0_wr;
   assign req1        = bus.d1_rd | bus.d1_wr;
   assign any_req     = req0 | req1;
   // With both requesting the client that was not served last wins.
   assign pick        = (req0 & req1) ? ~last_q : req1;
   assign pick_lba    = pick ? bus.d1_lba : bus.d0_lba;
   assign pick_wr     = pick ? bus.d1_wr : bus.d0_wr;
   assign grantee_req = grant_q ? req1 : req0;
   assign ack_fall    = old_ack_q & ~bus.sd_ack;
   assign in_xfer     = (state_q == XFER);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         orphan_q  <= 1'b0;
         old_ack_q <= 1'b0;
         sd_rd_q   <= 1'b0;
         sd_wr_q   <= 1'b0;
         sd_lba_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         orphan_q  <= orphan_d;
         old_ack_q <= old_ack_d;
         sd_rd_q   <= sd_rd_d;
         sd_wr_q   <= sd_wr_d;
         sd_lba_q  <= sd_lba_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = XFER;
         XFER:    if (ack_fall) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d   = grant_q;
      last_d    = last_q;
      orphan_d  = orphan_q;
      old_ack_d = bus.sd_ack;
      sd_rd_d   = sd_rd_q;
      sd_wr_d   = sd_wr_q;
      sd_lba_d  = sd_lba_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d  = pick;
               last_d   = pick;
               sd_lba_d = pick_lba;
               sd_wr_d  = pick_wr;
               sd_rd_d  = ~pick_wr;
               orphan_d = 1'b0;
            end
         end
         XFER: begin
            if (bus.sd_ack) begin
               sd_rd_d = 1'b0;
               sd_wr_d = 1'b0;
            end else if (!old_ack_q && !grantee_req) begin
               // Grantee gave up before the host answered; stay in XFER in case
               // the host already latched the request, but hide its ack.
               orphan_d = 1'b1;
               sd_rd_d  = 1'b0;
               sd_wr_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.sd_lba      = sd_lba_q;
      bus.sd_rd       = sd_rd_q;
      bus.sd_wr       = sd_wr_q;
      bus.owner       = grant_q;
      bus.busy        = (state_q != IDLE);
      bus.d0_ack      = bus.sd_ack & in_xfer & ~grant_q & ~orphan_q;
      bus.d1_ack      = bus.sd_ack & in_xfer & grant_q & ~orphan_q;
      bus.d0_buff_wr  = bus.sd_buff_wr & bus.d0_ack;
      bus.d1_buff_wr  = bus.sd_buff_wr & bus.d1_ack;
      bus.sd_buff_din = grant_q ? bus.d1_buff_din : bus.d0_buff_din;
   end
endmodule

// File: tb/tb_floppy_sd_arbiter.sv
// tb/tb_floppy_sd_arbiter.sv - scoreboard bench for floppy_sd_arbiter with a random SD host
module tb_floppy_sd_arbiter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   floppy_sd_arbiter_if sif ();
   floppy_sd_arbiter dut (.clk(clk), .reset(reset), .bus(sif.master));

   typedef struct {
      int          client;
      logic [31:0] lba;
      bit          wr;
      bit          chk_gap;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   issues = 0;
   int   fall_edge = -100;
   int   cur_client = 0;
   bit   xfer_active = 1'b0;
   bit   orphaned = 1'b0;
   bit   model_last = 1'b1;
   bit   auto_drop = 1'b1;
   bit   host_en = 1'b1;
   bit   host_busy = 1'b0;
   int   pulse_req = 0;
   int   pulse_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_bound(input string name, input int n, input int limit);
      n_checks++;
      if (n >= limit) begin
         n_fail++;
         $display("FAIL %s: waited %0d cycles, limit %0d", name, n, limit);
      end
   endtask

   // Reference: whole-sector round robin, ties broken away from the last grantee.
   task automatic push_round(input bit r0, input bit r1, input logic [31:0] l0,
                             input logic [31:0] l1, input bit w0, input bit w1,
                             input bit gap_first);
      exp_t e0, e1;
      e0 = '{0, l0, w0, 1'b0};
      e1 = '{1, l1, w1, 1'b0};
      if (r0 && r1) begin
         if (model_last) begin
            e0.chk_gap = gap_first; e1.chk_gap = 1'b1;
            exp_q.push_back(e0); exp_q.push_back(e1); model_last = 1'b1;
         end else begin
            e1.chk_gap = gap_first; e0.chk_gap = 1'b1;
            exp_q.push_back(e1); exp_q.push_back(e0); model_last = 1'b0;
         end
      end else if (r0) begin
         e0.chk_gap = gap_first; exp_q.push_back(e0); model_last = 1'b0;
      end else if (r1) begin
         e1.chk_gap = gap_first; exp_q.push_back(e1); model_last = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_drop) begin
         if (sif.d0_ack) begin sif.d0_rd = 1'b0; sif.d0_wr = 1'b0; end
         if (sif.d1_ack) begin sif.d1_rd = 1'b0; sif.d1_wr = 1'b0; end
      end
   endtask

   task automatic wait_issues(input int target, input string name);
      int n = 0;
      while (issues < target && n < 300) begin tick(); n++; end
      check_bound(name, n, 300);
   endtask

   task automatic wait_served(input int target, input string name);
      int n = 0;
      while (!(issues >= target && !sif.busy && !host_busy &&
               !(sif.d0_rd | sif.d0_wr | sif.d1_rd | sif.d1_wr)) && n < 400) begin
         tick(); n++;
      end
      check_bound(name, n, 400);
   endtask

   // SD host: answers each upstream request with an ack pulse of random length.
   initial begin : host
      bit manual;
      int len, dly;
      sif.sd_ack = 1'b0; sif.sd_buff_wr = 1'b0; sif.sd_buff_addr = 9'd0; sif.sd_buff_dout = 8'd0;
      forever begin
         @(negedge clk);
         if (pulse_req != pulse_done || (host_en && (sif.sd_rd || sif.sd_wr))) begin
            manual = (pulse_req != pulse_done);
            len = manual ? 4 : $urandom_range(1, 5);
            dly = manual ? 0 : $urandom_range(0, 2);
            host_busy = 1'b1;
            repeat (dly) @(posedge clk);
            @(posedge clk); #2;
            sif.sd_ack = 1'b1;
            for (int i = 0; i < len; i++) begin
               sif.sd_buff_wr   = manual ? 1'b1 : 1'($urandom_range(0, 1));
               sif.sd_buff_addr = 9'(i);
               sif.sd_buff_dout = 8'($urandom);
               @(posedge clk); #2;
            end
            sif.sd_ack = 1'b0; sif.sd_buff_wr = 1'b0;
            if (manual) pulse_done++;
            host_busy = 1'b0;
         end
      end
   end

   initial begin : monitor
      bit   prev_req, prev_ack, prev_rst;
      bit   a0, a1;
      exp_t e;
      prev_req = 1'b0; prev_ack = 1'b0; prev_rst = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_rst) xfer_active = 1'b0;
         if ((sif.sd_rd | sif.sd_wr) && !prev_req) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_issue: lba %0h owner %0d with empty queue", sif.sd_lba, sif.owner);
            end else begin
               e = exp_q.pop_front();
               check("issue_owner", 32'(sif.owner), 32'(e.client));
               check("issue_lba", sif.sd_lba, e.lba);
               check("issue_wr", 32'(sif.sd_wr), 32'(e.wr));
               check("issue_rd", 32'(sif.sd_rd), 32'(!e.wr));
               if (e.chk_gap) check("issue_gap", 32'(cyc - fall_edge), 32'd2);
               cur_client = e.client;
               xfer_active = 1'b1;
            end
            issues++;
         end
         if (sif.sd_ack || sif.sd_buff_wr) begin
            a0 = sif.sd_ack && xfer_active && cur_client == 0 && !orphaned;
            a1 = sif.sd_ack && xfer_active && cur_client == 1 && !orphaned;
            check("d0_ack", 32'(sif.d0_ack), 32'(a0));
            check("d1_ack", 32'(sif.d1_ack), 32'(a1));
            check("d0_buff_wr", 32'(sif.d0_buff_wr), 32'(a0 & sif.sd_buff_wr));
            check("d1_buff_wr", 32'(sif.d1_buff_wr), 32'(a1 & sif.sd_buff_wr));
            if (sif.sd_ack && xfer_active)
               check("sd_buff_din", 32'(sif.sd_buff_din),
                     32'(cur_client == 1 ? sif.d1_buff_din : sif.d0_buff_din));
         end
         if (prev_ack && !sif.sd_ack) begin
            fall_edge = cyc + 1;
            xfer_active = 1'b0;
         end
         prev_req = sif.sd_rd | sif.sd_wr;
         prev_ack = sif.sd_ack;
         prev_rst = reset;
      end
   end

   initial begin : stim
      int          base, n, m, dm0, dm1;
      bit          r0, r1;
      logic [31:0] la, lb;
      reset = 1'b1;
      sif.d0_rd = 1'b0; sif.d0_wr = 1'b0; sif.d1_rd = 1'b0; sif.d1_wr = 1'b0;
      sif.d0_lba = 32'd0; sif.d1_lba = 32'd0; sif.d0_buff_din = 8'h00; sif.d1_buff_din = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_sd_rd", 32'(sif.sd_rd), 32'd0);
      check("rst_sd_wr", 32'(sif.sd_wr), 32'd0);
      check("rst_sd_lba", sif.sd_lba, 32'd0);
      check("rst_owner", 32'(sif.owner), 32'd0);
      check("rst_busy", 32'(sif.busy), 32'd0);
      check("rst_d0_ack", 32'(sif.d0_ack), 32'd0);
      check("rst_d1_ack", 32'(sif.d1_ack), 32'd0);

      // Single read from drive 0.
      tick();
      base = issues;
      push_round(1'b1, 1'b0, 32'd13, 32'd0, 1'b0, 1'b0, 1'b0);
      sif.d0_lba = 32'd13; sif.d0_rd = 1'b1;
      wait_issues(base + 1, "single_issue");
      n = 0;
      while (sif.busy && n < 100) begin tick(); n++; end
      check_bound("single_busy_wait", n, 100);
      check("single_busy_fall", 32'(cyc - fall_edge), 32'd1);
      wait_served(base + 1, "single_done");

      // Write wins over read on drive 1; data comes from drive 1.
      base = issues;
      sif.d0_buff_din = 8'h3C; sif.d1_buff_din = 8'hA5;
      push_round(1'b0, 1'b1, 32'd0, 32'h0000_0777, 1'b0, 1'b1, 1'b0);
      sif.d1_lba = 32'h0000_0777; sif.d1_rd = 1'b1; sif.d1_wr = 1'b1;
      wait_served(base + 1, "write_done");

      // Contention: both hold requests across four sectors.
      base = issues;
      la = 32'h0000_1000; lb = 32'h0000_2000;
      push_round(1'b1, 1'b1, la, lb, 1'b0, 1'b0, 1'b0);
      push_round(1'b1, 1'b1, la, lb, 1'b0, 1'b0, 1'b1);
      auto_drop = 1'b0;
      sif.d0_lba = la; sif.d1_lba = lb; sif.d0_rd = 1'b1; sif.d1_rd = 1'b1;
      n = 0;
      while (!(issues >= base + 4 && sif.sd_ack) && n < 500) begin tick(); n++; end
      check_bound("contention_wait", n, 500);
      sif.d0_rd = 1'b0; sif.d1_rd = 1'b0;
      auto_drop = 1'b1;
      wait_served(base + 4, "contention_done");

      // Orphan: drive 0 withdraws before the host acks; drive 1 waits behind it.
      base = issues;
      host_en = 1'b0; auto_drop = 1'b0;
      push_round(1'b1, 1'b0, 32'h0000_0042, 32'd0, 1'b0, 1'b0, 1'b0);
      sif.d0_lba = 32'h0000_0042; sif.d0_rd = 1'b1;
      wait_issues(base + 1, "orphan_issue");
      sif.d0_rd = 1'b0; orphaned = 1'b1;
      push_round(1'b0, 1'b1, 32'd0, 32'h0000_0099, 1'b0, 1'b0, 1'b1);
      sif.d1_lba = 32'h0000_0099; sif.d1_rd = 1'b1;
      tick();
      @(negedge clk);
      check("orphan_sd_rd_drop", 32'(sif.sd_rd), 32'd0);
      pulse_req++;
      wait_issues(base + 2, "orphan_next_issue");
      orphaned = 1'b0; host_en = 1'b1; auto_drop = 1'b1;
      wait_served(base + 2, "orphan_done");

      // Randomised rounds.
      for (int r = 0; r < 30; r++) begin
         m = $urandom_range(1, 3); dm0 = $urandom_range(1, 3); dm1 = $urandom_range(1, 3);
         r0 = m[0]; r1 = m[1];
         la = $urandom; lb = $urandom;
         sif.d0_buff_din = 8'($urandom); sif.d1_buff_din = 8'($urandom);
         base = issues;
         push_round(r0, r1, la, lb, dm0[1], dm1[1], 1'b0);
         sif.d0_lba = la; sif.d1_lba = lb;
         sif.d0_rd = r0 & dm0[0]; sif.d0_wr = r0 & dm0[1];
         sif.d1_rd = r1 & dm1[0]; sif.d1_wr = r1 & dm1[1];
         wait_served(base + int'(r0) + int'(r1), "random_done");
         repeat ($urandom_range(0, 3)) tick();
      end

      // Reset during an acked transfer, then contention restarts at drive 0.
      base = issues;
      push_round(1'b0, 1'b1, 32'd0, 32'h0000_0555, 1'b0, 1'b0, 1'b0);
      sif.d1_lba = 32'h0000_0555; sif.d1_rd = 1'b1;
      n = 0;
      while (!sif.sd_ack && n < 100) begin tick(); n++; end
      check_bound("rstmid_ack_wait", n, 100);
      auto_drop = 1'b0;
      reset = 1'b1;
      sif.d0_lba = 32'h0000_0AAA; sif.d0_rd = 1'b1; sif.d1_rd = 1'b1;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         check("rstmid_sd_rd", 32'(sif.sd_rd), 32'd0);
         check("rstmid_sd_wr", 32'(sif.sd_wr), 32'd0);
         check("rstmid_d0_ack", 32'(sif.d0_ack), 32'd0);
         check("rstmid_d1_ack", 32'(sif.d1_ack), 32'd0);
         check("rstmid_busy", 32'(sif.busy), 32'd0);
         n++;
      end while ((host_busy || n < 2) && n < 20);
      model_last = 1'b1;
      base = issues;
      push_round(1'b1, 1'b1, 32'h0000_0AAA, 32'h0000_0555, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0; auto_drop = 1'b1;
      wait_served(base + 2, "rstmid_done");

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
